// File: rtl/uart_rx.sv
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver with mid-bit sampling, false-start rejection
//            and stop-bit checking. Optional macro UART_RX_SYNC_EN adds a
//            two-flop input synchroniser on rx.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx #(
    parameter int SIZE       = 8,
    parameter int BAUD_COUNT = 9,
    parameter int MID        = (BAUD_COUNT - 1) / 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rx,
    output logic [SIZE-1:0] data_out,
    output logic            rx_done,
    output logic            rx_busy,
    output logic            frame_err
);

    localparam int CNT_W = $clog2(SIZE + 1);

    localparam logic [3:0]       MID_C    = 4'(MID);
    localparam logic [3:0]       LAST_C   = 4'(BAUD_COUNT - 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SIZE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       clk_cycle_q, clk_cycle_d;
    logic [CNT_W-1:0] bit_counter_q, bit_counter_d;
    logic [SIZE-1:0]  shift_q, shift_d;
    logic [SIZE-1:0]  data_q, data_d;
    logic             done_q, done_d;
    logic             ferr_q, ferr_d;
    logic             busy_q, busy_d;
    logic             rx_s;

`ifdef UART_RX_SYNC_EN
    // Flops reset high so a reset never looks like a start bit.
    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    assign rx_s = sync_q[1];
`else
    assign rx_s = rx;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            clk_cycle_q   <= '0;
            bit_counter_q <= '0;
            shift_q       <= '0;
            data_q        <= '0;
            done_q        <= 1'b0;
            ferr_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            clk_cycle_q   <= clk_cycle_d;
            bit_counter_q <= bit_counter_d;
            shift_q       <= shift_d;
            data_q        <= data_d;
            done_q        <= done_d;
            ferr_q        <= ferr_d;
            busy_q        <= busy_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        clk_cycle_d   = clk_cycle_q;
        bit_counter_d = bit_counter_q;
        shift_d       = shift_q;
        data_d        = data_q;
        done_d        = 1'b0;
        ferr_d        = 1'b0;
        busy_d        = busy_q;

        case (state_q)
            IDLE: begin
                busy_d        = 1'b0;
                clk_cycle_d   = '0;
                bit_counter_d = '0;
                if (!rx_s) begin
                    state_d = START;
                    busy_d  = 1'b1;
                end
            end

            START: begin
                if (clk_cycle_q == MID_C) begin
                    clk_cycle_d = '0;
                    if (!rx_s) begin
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    clk_cycle_d = clk_cycle_q + 4'd1;
                end
            end

            DATA: begin
                if (clk_cycle_q == LAST_C) begin
                    // LSB arrives first, so shifting right leaves it at bit 0.
                    clk_cycle_d   = '0;
                    shift_d       = {rx_s, shift_q[SIZE-1:1]};
                    bit_counter_d = bit_counter_q + 1'b1;
                    if (bit_counter_q == LAST_BIT) begin
                        state_d = STOP;
                    end
                end else begin
                    clk_cycle_d = clk_cycle_q + 4'd1;
                end
            end

            STOP: begin
                if (clk_cycle_q == LAST_C) begin
                    if (rx_s) begin
                        data_d = shift_q;
                        done_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                    // Leaving at mid-stop-bit leaves half a bit to catch the next start.
                    state_d       = IDLE;
                    busy_d        = 1'b0;
                    bit_counter_d = '0;
                    clk_cycle_d   = '0;
                end else begin
                    clk_cycle_d = clk_cycle_q + 4'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign data_out  = data_q;
    assign rx_done   = done_q;
    assign frame_err = ferr_q;
    assign rx_busy   = busy_q;

endmodule

`default_nettype wire
